// File: rtl/pet2001uart_pacer_pkg.sv
// Shared constants and state encodings for the PET UART pacer path.
// The state values are also decoded by pet2001uart_keys.
package pet2001uart_pacer_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_WAIT = 2'd2
    } pacer_state_t;

endpackage

// File: rtl/pet2001uart_fifo.sv
// Single-clock character FIFO with first-word fall-through head.
// Full-with-pop accepts the push so a draining FIFO never drops a char.
module pet2001uart_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign full  = (r_count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset && !clear)
            r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/pet2001uart_pacer.sv
// Buffers received UART characters and releases them no faster than the
// PET keyboard scan can register them, with a longer gap after CR.
module pet2001uart_pacer
    import pet2001uart_pacer_pkg::*;
#(
    parameter int DEPTH_LOG2     = 4,
    parameter int PACE_CYCLES    = 2500000,
    parameter int CR_PACE_CYCLES = 10000000,
    parameter int CNT_W          = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_strobe,
    input  logic                clk_stop,
    input  logic                flush,
    output logic [7:0]          out_data,
    output logic                out_strobe,
    output logic                overflow,
    output logic [DEPTH_LOG2:0] fifo_count
);

    localparam logic [CNT_W-1:0] PACE_RELOAD = CNT_W'(PACE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CR_RELOAD   = CNT_W'(CR_PACE_CYCLES - 1);

    pacer_state_t     r_state;
    pacer_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_out_data;
    logic             r_out_strobe;
    logic             r_overflow;

    logic [7:0]       w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = (r_state == ST_EMIT);
    assign w_push = in_strobe && !flush;

    pet2001uart_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (in_data),
        .dout  (w_head),
        .count (fifo_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty && !clk_stop)
                    w_state_nxt = ST_EMIT;
            end
            ST_EMIT: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (r_cnt == '0 && !clk_stop)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_out_data   <= 8'h00;
            r_out_strobe <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (flush) begin
            // out_data deliberately keeps the last emitted character
            r_state      <= ST_IDLE;
            r_out_strobe <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_out_strobe <= w_pop;
            if (w_pop) begin
                r_out_data <= w_head;
                r_cnt      <= (w_head == ASCII_CR) ? CR_RELOAD : PACE_RELOAD;
            end else if (r_state == ST_WAIT && !clk_stop && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (in_strobe && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    assign out_data   = r_out_data;
    assign out_strobe = r_out_strobe;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_pet2001uart_pacer.sv
// Scoreboard bench for pet2001uart_pacer: expected chars are queued on
// send, strobes are captured by a monitor and compared per scenario.
module tb_pet2001uart_pacer;

    localparam int DL  = 2;
    localparam int PC  = 10;
    localparam int CRC = 30;
    localparam int CW  = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_strobe;
    logic          clk_stop;
    logic          flush;
    logic [7:0]    out_data;
    logic          out_strobe;
    logic          overflow;
    logic [DL:0]   fifo_count;

    pet2001uart_pacer #(
        .DEPTH_LOG2     (DL),
        .PACE_CYCLES    (PC),
        .CR_PACE_CYCLES (CRC),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_strobe  (in_strobe),
        .clk_stop   (clk_stop),
        .flush      (flush),
        .out_data   (out_data),
        .out_strobe (out_strobe),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [7:0] d;
    } ev_t;

    int         cyc = 0;
    int         peak = 0;
    int         checks = 0;
    int         errors = 0;
    ev_t        obs_q[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (out_strobe === 1'b1) begin
            e.c = cyc;
            e.d = out_data;
            obs_q.push_back(e);
        end
        if (int'(fifo_count) > peak)
            peak = int'(fifo_count);
    end

    // Called at a negedge; drives one strobe cycle, returns at the next negedge.
    task automatic send(input logic [7:0] d, input bit expect_out);
        in_data   = d;
        in_strobe = 1'b1;
        if (expect_out)
            exp_q.push_back(d);
        @(negedge clk);
        in_strobe = 1'b0;
    endtask

    task automatic get_obs(input int budget, output bit ok, output ev_t e);
        int n = 0;
        ok = 1'b0;
        e.c = -1;
        e.d = 8'hxx;
        while (obs_q.size() == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (obs_q.size() != 0) begin
            e  = obs_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_data got %h want 00", out_data);
        end
        checks++;
        if (out_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_strobe got %b want 0", out_strobe);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow got %b want 0", overflow);
        end
        checks++;
        if (fifo_count !== '0) begin
            errors++;
            $display("FAIL reset_fifo_count got %0d want 0", fifo_count);
        end
        reset = 1'b0;
        @(negedge clk);
        obs_q.delete();
    endtask

    task automatic test_single;
        int  n0;
        bit  ok;
        ev_t e;
        logic [7:0] x;
        n0 = cyc;
        send(8'h41, 1'b1);
        get_obs(20, ok, e);
        x = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (!ok || e.d !== x) begin
            errors++;
            $display("FAIL single_data got %h want %h", e.d, x);
        end
        checks++;
        if (e.c != n0 + 3) begin
            errors++;
            $display("FAIL single_latency got %0d want %0d", e.c - n0, 3);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (obs_q.size() != 0 || fifo_count !== '0) begin
            errors++;
            $display("FAIL single_quiet got %0d strobes cnt %0d want 0 0",
                     obs_q.size(), fifo_count);
        end
        obs_q.delete();
    endtask

    task automatic run_seq(input string name, input logic [7:0] chars[3],
                           input int gap[3]);
        int  n0;
        int  prev;
        bit  ok;
        ev_t e;
        logic [7:0] x;
        n0 = cyc;
        prev = 0;
        peak = 0;
        for (int i = 0; i < 3; i++)
            send(chars[i], 1'b1);
        for (int i = 0; i < 3; i++) begin
            get_obs(60, ok, e);
            x = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (!ok || e.d !== x) begin
                errors++;
                $display("FAIL %s_data%0d got %h want %h", name, i, e.d, x);
            end
            checks++;
            if ((i == 0 && e.c != n0 + 3) || (i > 0 && e.c - prev != gap[i])) begin
                errors++;
                $display("FAIL %s_gap%0d got %0d want %0d", name, i,
                         (i == 0) ? e.c - n0 : e.c - prev,
                         (i == 0) ? 3 : gap[i]);
            end
            prev = e.c;
        end
        @(negedge clk);
        repeat (40) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL %s_extra got %0d strobes want 0", name, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_burst;
        logic [7:0] c[3];
        int         g[3];
        c = '{8'h41, 8'h42, 8'h43};
        g = '{0, PC + 2, PC + 2};
        run_seq("burst", c, g);
        checks++;
        if (peak != 2) begin
            errors++;
            $display("FAIL burst_peak got %0d want 2", peak);
        end
    endtask

    task automatic test_cr;
        logic [7:0] c[3];
        int         g[3];
        c = '{8'h41, 8'h0D, 8'h42};
        g = '{0, PC + 2, CRC + 2};
        run_seq("cr", c, g);
    endtask

    task automatic test_overflow;
        int  prev;
        bit  ok;
        ev_t e;
        logic [7:0] x;
        for (int i = 0; i < 6; i++)
            send(8'h61 + 8'(i), i < 5);
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL ovf_set got ovf %b cnt %0d want 1 4", overflow, fifo_count);
        end
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            get_obs(40, ok, e);
            x = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (!ok || e.d !== x || (i > 0 && e.c - prev != PC + 2)) begin
                errors++;
                $display("FAIL ovf_char%0d got %h gap %0d want %h gap %0d",
                         i, e.d, e.c - prev, x, PC + 2);
            end
            prev = e.c;
        end
        @(negedge clk);
        clk_stop = 1'b1;
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL ovf_hold got ovf %b cnt %0d want 1 2", overflow, fifo_count);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (overflow !== 1'b0 || fifo_count !== '0 || out_strobe !== 1'b0) begin
            errors++;
            $display("FAIL flush got ovf %b cnt %0d stb %b want 0 0 0",
                     overflow, fifo_count, out_strobe);
        end
        checks++;
        if (out_data !== 8'h65) begin
            errors++;
            $display("FAIL flush_out_data got %h want 65", out_data);
        end
        clk_stop = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL flush_quiet got %0d strobes want 0", obs_q.size());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_suspend;
        int  n0;
        bit  ok;
        ev_t e;
        logic [7:0] x;
        n0 = cyc;
        send(8'h41, 1'b1);
        send(8'h42, 1'b1);
        while (cyc < n0 + 6) @(negedge clk);
        clk_stop = 1'b1;
        while (cyc < n0 + 10) @(negedge clk);
        send(8'h43, 1'b1);
        checks++;
        if (fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL suspend_retain got %0d want 2", fifo_count);
        end
        while (cyc < n0 + 56) @(negedge clk);
        clk_stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            int want;
            want = (i == 0) ? n0 + 3 : (i == 1) ? n0 + 3 + PC + 2 + 50
                                                : n0 + 3 + 2 * (PC + 2) + 50;
            get_obs(80, ok, e);
            x = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (!ok || e.d !== x || e.c != want) begin
                errors++;
                $display("FAIL suspend_char%0d got %h @%0d want %h @%0d",
                         i, e.d, e.c - n0, x, want - n0);
            end
        end
        @(negedge clk);
        repeat (20) @(negedge clk);
        obs_q.delete();
    endtask

    task automatic test_reset_mid;
        int  n0;
        bit  ok;
        ev_t e;
        logic [7:0] x;
        n0 = cyc;
        send(8'h41, 1'b1);
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        get_obs(20, ok, e);
        x = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (!ok || e.d !== x) begin
            errors++;
            $display("FAIL rstmid_first got %h want %h", e.d, x);
        end
        @(negedge clk);
        while (cyc < n0 + 6) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_buffered got %0d want 2", fifo_count);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (out_data !== 8'h00 || out_strobe !== 1'b0 ||
            overflow !== 1'b0 || fifo_count !== '0) begin
            errors++;
            $display("FAIL rstmid_state got %h %b %b %0d want 00 0 0 0",
                     out_data, out_strobe, overflow, fifo_count);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (obs_q.size() != 0 || fifo_count !== '0) begin
            errors++;
            $display("FAIL rstmid_quiet got %0d strobes cnt %0d want 0 0",
                     obs_q.size(), fifo_count);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = 8'h00;
        in_strobe = 1'b0;
        clk_stop  = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        test_reset;
        test_single;
        test_burst;
        test_cr;
        test_overflow;
        test_suspend;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
